// File: rtl/aes_iterative_inv_cipher_if.sv
// Key-load and block-decrypt handshake bundle for the iterative AES-128 inverse cipher.
// The slave modport is the decryptor; the master modport is the upstream/consumer side.
interface aes_iterative_inv_cipher_if #(
  parameter int DATA_W = 128,
  parameter int KEY_L  = 128
);
  logic              key_valid_in;
  logic [KEY_L-1:0]  cipher_key;
  logic              key_ready_out;
  logic              data_valid_in;
  logic [DATA_W-1:0] cipher_text;
  logic              data_ready_out;
  logic              valid_out;
  logic [DATA_W-1:0] plain_text;

  modport slave (
    input  key_valid_in, cipher_key, data_valid_in, cipher_text,
    output key_ready_out, data_ready_out, valid_out, plain_text
  );

  modport master (
    output key_valid_in, cipher_key, data_valid_in, cipher_text,
    input  key_ready_out, data_ready_out, valid_out, plain_text
  );
endinterface

// File: rtl/aes_iterative_inv_cipher.sv
// Iterative AES-128 inverse cipher: expands the key once into 11 stored round keys,
// then decrypts one block at a time, one round per clock (11-cycle latency).
module aes_iterative_inv_cipher #(
  parameter int DATA_W    = 128,
  parameter int KEY_L     = 128,
  parameter int NO_ROUNDS = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  aes_iterative_inv_cipher_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEYEXP, READY, DEC} state_t;

  localparam logic [3:0] LAST_RND = 4'(NO_ROUNDS);

  // GF(2^8) arithmetic; the S-boxes are derived from the field inverse x^254.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t            state_reg, state_next;
  logic [3:0]        rnd_reg;
  logic [DATA_W-1:0] st_reg;
  logic [DATA_W-1:0] plain_reg;
  logic              valid_reg;
  logic [KEY_L-1:0]  rk_reg [0:NO_ROUNDS];

  logic key_ready;
  logic data_ready;
  logic key_accept;
  logic data_accept;

  assign key_ready   = (state_reg == IDLE) || (state_reg == READY);
  assign data_ready  = (state_reg == READY) && !bus.key_valid_in;
  assign key_accept  = bus.key_valid_in && key_ready;
  assign data_accept = bus.data_valid_in && data_ready;

  assign bus.key_ready_out  = key_ready;
  assign bus.data_ready_out = data_ready;
  assign bus.valid_out      = valid_reg;
  assign bus.plain_text     = plain_reg;

  // Key expansion: one 128-bit round key per cycle from the previous one.
  logic [KEY_L-1:0] prev_rk;
  logic [KEY_L-1:0] next_rk;
  logic [31:0]      rot_word;
  logic [31:0]      sub_word;
  logic [31:0]      temp_word;

  assign prev_rk  = rk_reg[rnd_reg - 4'd1];
  assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
    end
  endgenerate

  assign temp_word          = sub_word ^ {rcon(rnd_reg), 24'h000000};
  assign next_rk[127:96]    = prev_rk[127:96] ^ temp_word;
  assign next_rk[95:64]     = prev_rk[95:64]  ^ next_rk[127:96];
  assign next_rk[63:32]     = prev_rk[63:32]  ^ next_rk[95:64];
  assign next_rk[31:0]      = prev_rk[31:0]   ^ next_rk[63:32];

  // Decrypt round datapath. Byte i sits at row i%4, column i/4 (MSB = byte 0).
  logic [DATA_W-1:0] isr;
  logic [DATA_W-1:0] isb;
  logic [DATA_W-1:0] ark;
  logic [DATA_W-1:0] round_out;
  logic [DATA_W-1:0] final_out;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int R   = gi % 4;
      localparam int C   = gi / 4;
      localparam int SRC = 4 * ((C - R + 4) % 4) + R;
      assign isr[127-8*gi -: 8] = st_reg[127-8*SRC -: 8];
      assign isb[127-8*gi -: 8] = inv_sbox(isr[127-8*gi -: 8]);
    end
  endgenerate

  assign ark       = isb ^ rk_reg[rnd_reg];
  assign final_out = isb ^ rk_reg[0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_imc
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ark[127-32*gi -: 8];
      assign a1 = ark[119-32*gi -: 8];
      assign a2 = ark[111-32*gi -: 8];
      assign a3 = ark[103-32*gi -: 8];
      assign round_out[127-32*gi -: 8] =
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      assign round_out[119-32*gi -: 8] =
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      assign round_out[111-32*gi -: 8] =
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      assign round_out[103-32*gi -: 8] =
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (key_accept) state_next = KEYEXP;
      KEYEXP:  if (rnd_reg == LAST_RND) state_next = READY;
      READY: begin
        if (key_accept)       state_next = KEYEXP;
        else if (data_accept) state_next = DEC;
      end
      DEC:     if (rnd_reg == 4'd0) state_next = READY;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd_reg   <= 4'd0;
      st_reg    <= '0;
      plain_reg <= '0;
      valid_reg <= 1'b0;
      for (int i = 0; i <= NO_ROUNDS; i++) rk_reg[i] <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE, READY: begin
          // A key in READY wins over data because data_ready is masked by it.
          if (key_accept) begin
            rk_reg[0] <= bus.cipher_key;
            rnd_reg   <= 4'd1;
          end else if (data_accept) begin
            st_reg  <= bus.cipher_text ^ rk_reg[NO_ROUNDS];
            rnd_reg <= LAST_RND - 4'd1;
          end
        end
        KEYEXP: begin
          rk_reg[rnd_reg] <= next_rk;
          rnd_reg         <= rnd_reg + 4'd1;
        end
        DEC: begin
          if (rnd_reg != 4'd0) begin
            st_reg  <= round_out;
            rnd_reg <= rnd_reg - 4'd1;
          end else begin
            plain_reg <= final_out;
            valid_reg <= 1'b1;
          end
        end
        default: rnd_reg <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iterative_inv_cipher.sv
// Directed-vector bench for the iterative AES-128 inverse cipher using FIPS-197 vectors.
module tb_aes_iterative_inv_cipher;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  aes_iterative_inv_cipher_if bus ();

  aes_iterative_inv_cipher dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_key(input string tag, input logic [127:0] k);
    @(negedge clk);
    bus.key_valid_in = 1'b1;
    bus.cipher_key   = k;
    @(posedge clk); #1;
    bus.key_valid_in = 1'b0;
    bus.cipher_key   = ~k;
    chk({tag, "_busy_start"}, 128'(bus.key_ready_out), 128'd0);
    repeat (9) @(posedge clk);
    #1 chk({tag, "_busy_cycle9"}, 128'(bus.key_ready_out), 128'd0);
    @(posedge clk); #1;
    chk({tag, "_key_ready"}, 128'(bus.key_ready_out), 128'd1);
    chk({tag, "_data_ready"}, 128'(bus.data_ready_out), 128'd1);
  endtask

  task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] pt);
    int lat;
    bit seen;
    @(negedge clk);
    bus.data_valid_in = 1'b1;
    bus.cipher_text   = ct;
    @(posedge clk); #1;
    bus.data_valid_in = 1'b0;
    bus.cipher_text   = ~ct;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.valid_out) seen = 1'b1;
    end
    chk({tag, "_latency"}, 128'(lat), 128'd10);
    chk({tag, "_pt"}, bus.plain_text, pt);
    @(posedge clk); #1;
    chk({tag, "_valid_strobe"}, 128'(bus.valid_out), 128'd0);
    chk({tag, "_pt_hold"}, bus.plain_text, pt);
  endtask

  initial begin
    int cyc;
    int pulses;
    int pulse_cyc [3];
    int stray;

    reset             = 1'b1;
    bus.key_valid_in  = 1'b0;
    bus.cipher_key    = '0;
    bus.data_valid_in = 1'b1;
    bus.cipher_text   = CT1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(bus.valid_out), 128'd0);
    chk("rst_pt", bus.plain_text, 128'd0);
    chk("rst_key_ready", 128'(bus.key_ready_out), 128'd1);
    chk("rst_data_ready", 128'(bus.data_ready_out), 128'd0);
    chk("rst_rk10", dut.rk_reg[10], 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_accept", 128'(bus.data_ready_out), 128'd0);
    bus.data_valid_in = 1'b0;

    // FIPS C.1 and appendix B vectors
    load_key("k1", KEY1);
    decrypt("c1", CT1, PT1);
    load_key("k2", KEY2);
    chk("k2_rk10", dut.rk_reg[10], RK10);
    decrypt("b", CT2, PT2);

    // Held data_valid: three back-to-back blocks
    @(negedge clk);
    bus.data_valid_in = 1'b1;
    bus.cipher_text   = CT2;
    cyc    = 0;
    pulses = 0;
    while (pulses < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.valid_out) begin
        pulse_cyc[pulses] = cyc;
        pulses++;
        chk($sformatf("hold_pt%0d", pulses), bus.plain_text, PT2);
        if (pulses == 3) bus.data_valid_in = 1'b0;
      end
    end
    bus.data_valid_in = 1'b0;
    chk("hold_pulses", 128'(pulses), 128'd3);
    chk("hold_first", 128'(pulse_cyc[0]), 128'd11);
    chk("hold_gap1", 128'(pulse_cyc[1] - pulse_cyc[0]), 128'd11);
    chk("hold_gap2", 128'(pulse_cyc[2] - pulse_cyc[1]), 128'd11);

    // Key and data together in READY: key wins
    @(negedge clk);
    bus.key_valid_in  = 1'b1;
    bus.cipher_key    = KEY1;
    bus.data_valid_in = 1'b1;
    bus.cipher_text   = CT2;
    #1 chk("prio_data_ready", 128'(bus.data_ready_out), 128'd0);
    @(posedge clk); #1;
    bus.key_valid_in  = 1'b0;
    bus.data_valid_in = 1'b0;
    chk("prio_keyexp", 128'(bus.key_ready_out), 128'd0);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.valid_out) stray++;
    end
    chk("prio_no_valid", 128'(stray), 128'd0);
    chk("prio_ready", 128'(bus.key_ready_out), 128'd1);
    decrypt("prio_dec", CT1, PT1);

    // Reset in the middle of a decrypt
    @(negedge clk);
    bus.data_valid_in = 1'b1;
    bus.cipher_text   = CT1;
    @(posedge clk); #1;
    bus.data_valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.data_valid_in = 1'b1;
    #1;
    chk("abort_valid", 128'(bus.valid_out), 128'd0);
    chk("abort_pt", bus.plain_text, 128'd0);
    chk("abort_idle", 128'(bus.key_ready_out), 128'd1);
    chk("abort_data_ready", 128'(bus.data_ready_out), 128'd0);
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.valid_out || bus.data_ready_out) stray++;
    end
    chk("abort_quiet", 128'(stray), 128'd0);
    bus.data_valid_in = 1'b0;
    load_key("k3", KEY2);
    decrypt("after_abort", CT2, PT2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
